// File: rtl/tau_pkg.sv
// Shared types and constants for the byte-wide core's fetch/execute sequencer.
package tau_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_INC, S_DECODE, S_MEM_RD, S_MEM_WR, S_WB, S_ERR
  } seq_state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [2:0] F3_BYTE  = 3'b000;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;

  // Byte-address EA: zero-extended base plus 24-bit offset, wrapping at 2^24.
  function automatic logic [23:0] eff_addr(input logic [7:0] base, input logic [23:0] off);
    return {16'h0000, base} + off;
  endfunction

endpackage

// File: rtl/fetch_exec_sequencer_if.sv
// Byte-wide flash bus between the sequencer (master) and the flash (slave).
interface fetch_exec_sequencer_if;
  logic        flash_we;
  logic        flash_re;
  logic [23:0] flash_addr;
  logic [7:0]  flash_in;
  logic [7:0]  flash_out;

  modport master (output flash_we, flash_re, flash_addr, flash_in, input flash_out);
  modport slave  (input flash_we, flash_re, flash_addr, flash_in, output flash_out);
endinterface

// File: rtl/flash_read_timer.sv
// Loadable down-counter; done is high in the last cycle of a READ_LAT-cycle flash read.
module flash_read_timer #(
  parameter int READ_LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);
  localparam logic [2:0] LOAD_VAL = 3'(READ_LAT - 1);

  logic [2:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (load)        cnt <= LOAD_VAL;
    else if (cnt != '0)   cnt <= cnt - 3'd1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle sequencer: fetches a 32-bit IR byte-by-byte from flash, then
// executes lb / sb / R-type writeback. All outputs are registered from next state.
module fetch_exec_sequencer
  import tau_pkg::*;
#(
  parameter int          READ_LAT     = 3,
  parameter logic [15:0] RETIRED_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [23:0] pc_out,
  output logic [1:0]  pc_control,
  fetch_exec_sequencer_if.master fbus,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic [31:0] imm,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [7:0]  rs1_data,
  input  logic [7:0]  rs2_data,
  input  logic [7:0]  alu_result,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic        busy,
  output logic        illegal,
  output logic [15:0] retired
);
  seq_state_e  state, state_d;
  logic [1:0]  bi, bi_d;
  logic [31:0] ir_d;
  logic [23:0] addr_q, addr_d, ea;
  logic [7:0]  fin_q, fin_d, wdata_d;
  logic [4:0]  waddr_d;
  logic [15:0] ret_d;
  logic        re_q, we_q, rf_we_d, ill_d, retire, tmr_load, tmr_done;
  logic [6:0]  opc;
  logic [2:0]  f3;

  // Register indices are consumed by the register file; only rd matters here.
  logic unused_cu;
  assign unused_cu = ^{rs1, rs2, imm[31:24]};

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign ea  = eff_addr(rs1_data, imm[23:0]);

  flash_read_timer #(.READ_LAT(READ_LAT)) u_tmr (
    .clk  (clk),
    .reset(reset),
    .load (tmr_load),
    .done (tmr_done)
  );

  always_comb begin
    state_d  = state;
    bi_d     = bi;
    ir_d     = ir;
    addr_d   = addr_q;
    fin_d    = fin_q;
    waddr_d  = rf_waddr;
    wdata_d  = rf_wdata;
    rf_we_d  = 1'b0;
    ill_d    = illegal;
    ret_d    = retired;
    tmr_load = 1'b0;
    retire   = 1'b0;
    case (state)
      S_IDLE: if (run) begin
        state_d  = S_FETCH;
        bi_d     = '0;
        addr_d   = pc_out;
        tmr_load = 1'b1;
      end
      S_FETCH: if (tmr_done) begin
        ir_d[8*bi +: 8] = fbus.flash_out;
        state_d         = S_INC;
      end
      // PC bumps on the edge leaving INC, so the next byte address is pc_out+1.
      S_INC: if (bi != 2'd3) begin
        bi_d     = bi + 2'd1;
        state_d  = S_FETCH;
        addr_d   = pc_out + 24'd1;
        tmr_load = 1'b1;
      end else begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opc == OP_LOAD && f3 == F3_BYTE) begin
          state_d  = S_MEM_RD;
          addr_d   = ea;
          tmr_load = 1'b1;
        end else if (opc == OP_STORE && f3 == F3_BYTE) begin
          state_d = S_MEM_WR;
          addr_d  = ea;
          fin_d   = rs2_data;
        end else if (opc == OP_REG) begin
          state_d = S_WB;
          waddr_d = rd;
          wdata_d = alu_result;
          rf_we_d = (rd != 5'd0);
        end else begin
          state_d = S_ERR;
          ill_d   = 1'b1;
        end
      end
      S_MEM_RD: if (tmr_done) begin
        state_d = S_WB;
        waddr_d = rd;
        wdata_d = fbus.flash_out;
        rf_we_d = (rd != 5'd0);
      end
      S_MEM_WR, S_WB: retire = 1'b1;
      S_ERR: ;
      default: ;
    endcase
    if (retire) begin
      ret_d = retired + 16'd1;
      ir_d  = '0;
      bi_d  = '0;
      if (run) begin
        state_d  = S_FETCH;
        addr_d   = pc_out;
        tmr_load = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      bi         <= '0;
      ir         <= '0;
      ir_valid   <= 1'b0;
      pc_control <= PC_HOLD;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      fin_q      <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      busy       <= 1'b0;
      illegal    <= 1'b0;
      retired    <= RETIRED_INIT;
    end else begin
      state      <= state_d;
      bi         <= bi_d;
      ir         <= ir_d;
      ir_valid   <= state_d inside {S_DECODE, S_MEM_RD, S_MEM_WR, S_WB};
      pc_control <= (state_d == S_INC) ? PC_INC : PC_HOLD;
      re_q       <= state_d inside {S_FETCH, S_MEM_RD};
      we_q       <= (state_d == S_MEM_WR);
      addr_q     <= addr_d;
      fin_q      <= fin_d;
      rf_we      <= rf_we_d;
      rf_waddr   <= waddr_d;
      rf_wdata   <= wdata_d;
      busy       <= !(state_d inside {S_IDLE, S_ERR});
      illegal    <= ill_d;
      retired    <= ret_d;
    end
  end

  assign fbus.flash_re   = re_q;
  assign fbus.flash_we   = we_q;
  assign fbus.flash_addr = addr_q;
  assign fbus.flash_in   = fin_q;
endmodule

// File: doc/fetch_exec_sequencer.md
# fetch_exec_sequencer

Multi-cycle sequencer for the byte-wide core. It fetches 32-bit instructions from the 8-bit flash one byte at a time, stepping the program counter, and assembles the instruction register. It then hands the IR to the control unit and executes the result: byte load, byte store or register-register ALU op. It sits between `program_counter`, `flash`, `control_unit`, `alu` and the register file, and replaces the hand-driven fetch/decode sequence used in bring-up benches.

## Interface
- `READ_LAT`, default 3: flash read latency in clocks from `re`/`addr` presented to `out` valid; legal range 1..7.
- `clk`  in  1  system clock (from `clock`).
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; while high the sequencer keeps fetching and executing.
- `pc_out`  in  24  current PC.
- `pc_control`  out  2  `00` hold, `01` increment; no other codes are driven.
- `flash_we`, `flash_re`  out  1 each  flash strobes.
- `flash_addr`  out  24  flash address.
- `flash_in`  out  8  flash write data.
- `flash_out`  in  8  flash read data.
- `ir`  out  32  assembled instruction; feeds the control unit.
- `ir_valid`  out  1  high from DECODE through the end of execute.
- `imm`  in  32  immediate from the control unit.
- `rs1`, `rs2`, `rd`  in  5 each  register indices from the control unit.
- `rs1_data`, `rs2_data`  in  8 each  register-file read data.
- `alu_result`  in  8  ALU result.
- `rf_we`  out  1  register-file write strobe.
- `rf_waddr`  out  5  register-file write index.
- `rf_wdata`  out  8  register-file write data.
- `busy`  out  1  high in any state other than IDLE and ERR.
- `illegal`  out  1  sticky; set on an unsupported instruction.
- `retired`  out  16  count of completed instructions; wraps at 2^16.

## Operation
- States: IDLE, FETCH, INC, DECODE, MEM_RD, MEM_WR, WB, ERR.
- IDLE: all strobes low. When `run`=1, load byte index `bi`=0 and go to FETCH.
- FETCH: `flash_re`=1, `flash_addr`=`pc_out`. Hold for READ_LAT cycles. On the last edge, latch `flash_out` into `ir[8*bi+7:8*bi]`, then go to INC.
- INC: `pc_control`=01 for exactly one cycle. If `bi`<3: `bi`++ and go to FETCH. Otherwise go to DECODE.
- DECODE: one cycle; `ir_valid` rises. Opcode is `ir[6:0]`, funct3 is `ir[14:12]`.
  - `0000011` with funct3 `000` (lb): go to MEM_RD.
  - `0100011` with funct3 `000` (sb): go to MEM_WR.
  - `0110011` (R-type): go to WB with source = ALU.
  - Anything else: set `illegal` and go to ERR.
- Effective address: EA = zero-extended `rs1_data` + `imm[23:0]`, modulo 2^24. Register x0 reads as 0 (register-file responsibility).
- MEM_RD: `flash_re`=1, `flash_addr`=EA for READ_LAT cycles. Latch `flash_out`, then go to WB with source = load.
- MEM_WR: one cycle with `flash_we`=1, `flash_addr`=EA, `flash_in`=`rs2_data`. Retire.
- WB: one cycle with `rf_we`=1, `rf_waddr`=`rd`, `rf_wdata` = latched load byte or `alu_result`. The write is suppressed when `rd`=0. Retire.
- Retire: `retired`++, clear `ir`. Go to FETCH (`bi`=0) if `run`=1, else go to IDLE.
- ERR: all strobes low. Leave only via reset.
- `run` dropping mid-instruction does not abort; the current instruction completes.

## Timing
- Reset values: state IDLE, `ir`=0, `ir_valid`=0, `pc_control`=00, `flash_we`/`flash_re`=0, `flash_addr`=0, `flash_in`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `busy`=0, `illegal`=0, `retired`=0.
- All outputs are registered; the state changes on the rising edge of `clk`.
- Fetch takes 4×(READ_LAT+1) cycles; with the default that is 16.
- Execute lengths: lb = 1 + READ_LAT + 1; sb = 1 + 1; R-type = 1 + 1.
- The PC advances exactly 4 per instruction. The sequencer never drives `pc_control`=01 while `flash_re`=1.
- `flash_we` and `flash_re` are never high together.
- Reset asserted mid-operation returns the block to IDLE immediately, with all strobes low in the same instant (asynchronous). Flash contents and PC state are not the sequencer's concern.
- `retired` wraps from 0xFFFF to 0x0000 without a flag.

## Structure
- Shared package `tau_pkg`:
  - state enum;
  - opcode constants `OP_LOAD`=7'b0000011, `OP_STORE`=7'b0100011, `OP_REG`=7'b0110011;
  - `F3_BYTE`=3'b000;
  - `PC_HOLD`=2'b00, `PC_INC`=2'b01.
- One sub-module, `flash_read_timer`: a loadable down-counter that pulses `done` after READ_LAT cycles. FETCH and MEM_RD both use it.

## Test plan
- Flash preloaded with 0x02000283 at address 0 and byte 0x11 at 0x20; `run`=1; reset released. Required:
  - `ir`=0x02000283 after 16 cycles;
  - PC=4;
  - `rf_we` pulse with `rf_waddr`=5, `rf_wdata`=0x11;
  - `retired`=1.
- R-type 0x006283b3 with `alu_result` forced to 0x22 -> WB writes 0x22 to x7, two cycles after DECODE.
- sb with `rs1_data`=0, `imm`=0x16, `rs2_data`=0x22 -> one cycle of `flash_we`=1 at address 0x000016 with data 0x22; `flash_re` stays low.
- Opcode 0x7F -> `illegal`=1, state ERR, no further `pc_control` or flash strobes until reset.
- Reset asserted during the third FETCH byte -> all outputs take their reset values in the same instant; a refetch after release starts at `bi`=0.
- READ_LAT=1 build, and `retired` preset near 0xFFFF -> fetch takes 8 cycles; the counter wraps to 0.
